mips32_mem_arbiter: RTL and testbench

Single-clock arbiter sharing the one 1024x32 unified instruction/data memory of the MIPS32 pipeline between three requesters. The requesters are the program loader, the MEM-stage data port (LW/SW) and the IF-stage fetch port. It grants at most one access per cycle, registers the command onto the memory port, and routes read data back to the requester that issued the read. It sits between the pipeline stages and the memory array. It replaces the direct `Mem[]` indexing done today by the fetch and memory stages.

---
 rtl/mips32_mem_pkg.sv | 24 ++
 rtl/mips32_mem_arb_pick.sv | 30 +++
 rtl/mips32_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 unified-memory arbiter: requester indices,
// arbiter states and default memory geometry.
package mips32_mem_pkg;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned MEM_DW = 32;

    localparam int unsigned REQ_LD = 0;
    localparam int unsigned REQ_DM = 1;
    localparam int unsigned REQ_IF = 2;

    typedef enum logic {ARB, LOCK} arb_state_e;

    // Requester index of a one-hot-or-zero grant vector (zero maps to LD, never used then).
    function automatic logic [1:0] gnt_owner(input logic [2:0] g);
        if (g[REQ_IF]) begin
            return 2'd2;
        end else if (g[REQ_DM]) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/mips32_mem_arb_pick.sv
// Combinational grant selection for the three memory requesters, plus the
// "this grant starts a loader burst" indication.
module mips32_mem_arb_pick
    import mips32_mem_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic       locked_i,
    input  logic       starve_i,
    input  logic       ld_lock_i,
    output logic [2:0] gnt_o,
    output logic       lock_take_o
);

    always_comb begin
        gnt_o = '0;
        if (locked_i) begin
            // Burst in progress: only the loader may touch memory.
            gnt_o[REQ_LD] = req_i[REQ_LD];
        end else if (req_i[REQ_LD]) begin
            gnt_o[REQ_LD] = 1'b1;
        end else if (req_i[REQ_DM] && !(req_i[REQ_IF] && starve_i)) begin
            gnt_o[REQ_DM] = 1'b1;
        end else if (req_i[REQ_IF]) begin
            gnt_o[REQ_IF] = 1'b1;
        end
    end

    assign lock_take_o = !locked_i && gnt_o[REQ_LD] && ld_lock_i;

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbiter sharing the unified 1024x32 memory between loader, data port and
// fetch port: one grant per cycle, registered command, tagged read return.
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int unsigned AW         = MEM_AW,
    parameter int unsigned DW         = MEM_DW,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    input  logic            ld_lock,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            locked
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    arb_state_e state_q, state_d;
    logic [3:0] starve_q, starve_d;

    logic [2:0]    pick_gnt;
    logic          lock_take;
    logic          any_gnt;
    logic [1:0]    sel;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          cmd_en_q, cmd_we_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_wdata_q;
    logic [1:0]    cmd_owner_q;
    logic          ret_vld_q;
    logic [1:0]    ret_owner_q;

    mips32_mem_arb_pick u_pick (
        .req_i       (req),
        .locked_i    (state_q == LOCK),
        .starve_i    (starve_q == StarveMax),
        .ld_lock_i   (ld_lock),
        .gnt_o       (pick_gnt),
        .lock_take_o (lock_take)
    );

    // Grants are forced off while reset is asserted, even with requests pending.
    assign gnt     = pick_gnt & {3{rst_n}};
    assign any_gnt = |pick_gnt;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:  if (lock_take) state_d = LOCK;
            LOCK: if (!ld_lock)  state_d = ARB;
        endcase
    end

    // FSM: outputs
    always_comb begin
        locked = (state_q == LOCK);
    end

    // Fetch starvation counter; only meaningful (and only moving) while arbitrating.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ARB) begin
            if (!req[REQ_IF] || pick_gnt[REQ_IF]) begin
                starve_d = '0;
            end else if (pick_gnt[REQ_DM] && starve_q < StarveMax) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        sel       = gnt_owner(pick_gnt);
        sel_we    = we[sel];
        sel_addr  = addr[sel*AW +: AW];
        sel_wdata = wdata[sel*DW +: DW];
    end

    // Command stage (T+1) and read-return tag stage (T+2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_en_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_owner_q <= '0;
            ret_vld_q   <= 1'b0;
            ret_owner_q <= '0;
        end else begin
            cmd_en_q <= any_gnt;
            cmd_we_q <= any_gnt & sel_we;
            if (any_gnt) begin
                cmd_addr_q  <= sel_addr;
                cmd_wdata_q <= sel_wdata;
                cmd_owner_q <= sel;
            end
            ret_vld_q   <= cmd_en_q & ~cmd_we_q;
            ret_owner_q <= cmd_owner_q;
        end
    end

    assign mem_en    = cmd_en_q;
    assign mem_we    = cmd_we_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

    always_comb begin
        rvalid = '0;
        if (ret_vld_q) begin
            rvalid[ret_owner_q] = 1'b1;
        end
        rdata = ret_vld_q ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Randomised bench for mips32_mem_arbiter with a transaction-level reference
// model (grant rules, shadow memory, expected command/return pipeline).
module tb_mips32_mem_arbiter;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      req = '0;
    logic [2:0]      we = '0;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic            ld_lock = 1'b0;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            mem_en, mem_we, locked;
    logic [AW-1:0]   mem_addr;

    mips32_mem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ld_lock   (ld_lock),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Synchronous memory array attached to the arbiter, with a preload path.
    logic [DW-1:0] mem [1024];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    // Reference model state.
    logic [DW-1:0] shadow [1024];
    bit            m_lock;
    int            m_starve;
    bit            ec_en, ec_we;
    logic [AW-1:0] ec_addr;
    logic [DW-1:0] ec_wdata, ec_rd;
    int            ec_owner;
    bit            er_v;
    int            er_owner;
    logic [DW-1:0] er_data;

    task automatic model_reset();
        m_lock   = 0;
        m_starve = 0;
        ec_en    = 0;
        ec_we    = 0;
        er_v     = 0;
    endtask

    // Winner under the arbitration rules, -1 when nobody is granted.
    function automatic int pick(input logic [2:0] r);
        if (m_lock) return r[0] ? 0 : -1;
        if (r[0]) return 0;
        if (r[1] && r[2]) return (m_starve >= STARVE_MAX) ? 2 : 1;
        if (r[1]) return 1;
        if (r[2]) return 2;
        return -1;
    endfunction

    // One clock cycle: check the grant for the driven inputs, advance the model,
    // then check the registered outputs just after the edge.
    task automatic tick(output logic [2:0] eg);
        int g;
        #1;
        g  = pick(req);
        eg = (g < 0) ? 3'b000 : 3'(1 << g);
        check_eq("gnt", 64'(gnt), 64'(eg));
        er_v     = ec_en && !ec_we;
        er_owner = ec_owner;
        er_data  = ec_rd;
        ec_en    = (g >= 0);
        if (g >= 0) begin
            ec_we    = we[g];
            ec_addr  = addr[g*AW +: AW];
            ec_wdata = wdata[g*DW +: DW];
            ec_owner = g;
            if (ec_we) shadow[ec_addr] = ec_wdata;
            else       ec_rd = shadow[ec_addr];
        end
        if (!m_lock) begin
            if (!req[2] || g == 2) m_starve = 0;
            else if (g == 1 && m_starve < STARVE_MAX) m_starve++;
            m_lock = (g == 0) && ld_lock;
        end else begin
            m_lock = ld_lock;
        end
        @(posedge clk);
        #1;
        check_eq("mem_en", 64'(mem_en), 64'(ec_en));
        if (ec_en) begin
            check_eq("mem_we", 64'(mem_we), 64'(ec_we));
            check_eq("mem_addr", 64'(mem_addr), 64'(ec_addr));
            if (ec_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(ec_wdata));
        end
        check_eq("rvalid", 64'(rvalid), er_v ? 64'(1 << er_owner) : 64'd0);
        if (er_v) check_eq("rdata", 64'(rdata), 64'(er_data));
        check_eq("locked", 64'(locked), 64'(m_lock));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"}, 64'(gnt), 64'd0);
        check_eq({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check_eq({tag, "_rdata"}, 64'(rdata), 64'd0);
        check_eq({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        check_eq({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check_eq({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check_eq({tag, "_locked"}, 64'(locked), 64'd0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(16) == 16) ? 10'd1023 : AW'($urandom_range(15));
    endfunction

    logic [2:0] eg;
    logic [2:0] seq [10] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100,
                             3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    int         prob [3] = '{10, 50, 70};
    logic [2:0] pend;
    bit         seen, dropped;

    initial begin
        model_reset();
        // Reset held with all requests asserted: everything must read zero.
        req = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        req   = '0;
        pl_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pl_addr = (i == 16) ? 10'd1023 : 10'(i);
            pl_data = (i == 5) ? 32'hDEADBEEF : $urandom;
            shadow[pl_addr] = pl_data;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
        rst_n = 1'b1;

        // Reset in the cycle after a DM read grant drops the return.
        req = 3'b010; we = '0; addr[1*AW +: AW] = 10'd7;
        tick(eg);
        req   = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_eq("rst_mid_no_rvalid", 64'(rvalid), 64'd0);
        model_reset();
        rst_n = 1'b1;
        tick(eg);

        // Basic fetch read of a preloaded word.
        req = 3'b100; we = '0; addr[2*AW +: AW] = 10'd5;
        tick(eg);
        check_eq("basic_en", 64'(mem_en), 64'd1);
        check_eq("basic_addr", 64'(mem_addr), 64'd5);
        req = '0;
        tick(eg);
        check_eq("basic_rvalid", 64'(rvalid), 64'b100);
        check_eq("basic_rdata", 64'(rdata), 64'hDEADBEEF);

        // Continuous DM/IF contention.
        req = 3'b110; we = '0; addr[1*AW +: AW] = 10'd3; addr[2*AW +: AW] = 10'd4;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("contend", 64'(gnt), 64'(seq[i]));
            tick(eg);
        end
        req = '0;
        tick(eg);

        // Write then read of the top word.
        req = 3'b010; we = 3'b010; addr[1*AW +: AW] = 10'd1023;
        wdata[1*DW +: DW] = 32'h12345678;
        tick(eg);
        req = 3'b100; we = '0; addr[2*AW +: AW] = 10'd1023;
        tick(eg);
        req = '0;
        tick(eg);
        check_eq("wr_rd_rvalid", 64'(rvalid), 64'b100);
        check_eq("wr_rd_rdata", 64'(rdata), 64'h12345678);

        // Loader burst under lock while fetch keeps requesting.
        ld_lock = 1'b1;
        we = 3'b001; addr[2*AW +: AW] = 10'd2;
        for (int i = 0; i < 8; i++) begin
            req = 3'b101;
            addr[0 +: AW] = 10'(i);
            wdata[0 +: DW] = $urandom;
            #1;
            check_eq("lock_if_gnt", 64'(gnt[2]), 64'd0);
            tick(eg);
            check_eq("lock_locked", 64'(locked), 64'd1);
        end
        ld_lock = 1'b0;
        req = 3'b100; we = '0;
        seen = 0;
        for (int j = 0; j < 2; j++) begin
            #1;
            seen |= gnt[2];
            tick(eg);
        end
        check_eq("lock_release", 64'(seen), 64'd1);
        req = '0;
        tick(eg);

        // DM request abandoned after losing to LD.
        req = 3'b011; we = 3'b010; addr[0 +: AW] = 10'd3; addr[1*AW +: AW] = 10'd9;
        wdata[1*DW +: DW] = 32'hAAAA5555;
        tick(eg);
        req = '0;
        for (int j = 0; j < 3; j++) begin
            tick(eg);
            check_eq("abandon", 64'(mem_en && mem_we), 64'd0);
        end

        // Randomised traffic obeying the request/grant handshake.
        pend = '0;
        eg   = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                dropped = 0;
                if (eg[i]) begin
                    pend[i] = 1'b0;
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                    dropped = 1;
                end
                if (!pend[i] && !dropped && $urandom_range(99) < prob[i]) begin
                    pend[i] = 1'b1;
                    we[i]   = 1'($urandom_range(1));
                    addr[i*AW +: AW]  = rand_addr();
                    wdata[i*DW +: DW] = $urandom;
                end
            end
            if ($urandom_range(9) == 0) ld_lock = !ld_lock;
            req = pend;
            tick(eg);
        end
        req = '0;
        ld_lock = 1'b0;
        tick(eg);
        tick(eg);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
